myadder1_example_number_checker: RTL and testbench

AXI4-Stream sink that sits directly downstream of the example number generator (or downstream of the adder datapath in loopback tests). It consumes one transfer of C_LENGTH_IN_BYTES, compares every byte against the generator's incrementing-lane pattern, and checks TLAST/TKEEP placement. It applies a programmable back-pressure pattern on TREADY and reports sticky error flags plus the first failing beat index on completion.

---
 rtl/myadder1_example_pkg.sv | 40 ++++
 rtl/myadder1_example_counter.sv | 19 +
 rtl/myadder1_example_number_checker.sv | 115 +++++++++++
 tb/tb_myadder1_example_number_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/myadder1_example_pkg.sv
// Shared types and helpers for the example number checker: FSM states,
// error-flag bit positions and the generator's expected-beat pattern.
package myadder1_example_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int ERR_DATA         = 0;
  localparam int ERR_EARLY_LAST   = 1;
  localparam int ERR_MISSING_LAST = 2;
  localparam int ERR_KEEP         = 3;

  localparam int MAX_TDATA_W = 1024;

  // Lane n of beat b: low s bits hold n, the remaining bits hold b (wrapping).
  function automatic logic [MAX_TDATA_W-1:0] expected_beat(input logic [31:0] b,
                                                           input int tdata_w,
                                                           input int nb,
                                                           input int s);
    logic [MAX_TDATA_W-1:0] word;
    int lane;
    int pos;
    word = '0;
    for (int i = 0; i < MAX_TDATA_W; i++) begin
      if (i < tdata_w) begin
        lane = i / nb;
        pos  = i % nb;
        if (pos < s)
          word[i] = ((lane >> pos) & 1) != 0;
        else
          word[i] = ((b >> (pos - s)) & 32'd1) != 32'd0;
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/myadder1_example_counter.sv
// Free-running up counter with synchronous clear, used as the beat index.
module myadder1_example_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (incr)
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/myadder1_example_number_checker.sv
// AXI4-Stream sink that checks one transfer against the example generator's
// lane pattern, applies a rotating TREADY mask and reports sticky errors.
module myadder1_example_number_checker
  import myadder1_example_pkg::*;
#(
  parameter int         C_S_AXIS_TDATA_WIDTH = 128,
  parameter int         C_NUMBER_BIT_WIDTH   = 32,
  parameter int         C_LENGTH_IN_BYTES    = 16384,
  parameter logic [7:0] C_READY_PATTERN      = 8'hFF
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_done,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic [3:0]                        err_flags,
  output logic [31:0]                       err_beat
);

  localparam int NB    = (C_NUMBER_BIT_WIDTH > C_S_AXIS_TDATA_WIDTH) ?
                         C_S_AXIS_TDATA_WIDTH : C_NUMBER_BIT_WIDTH;
  localparam int L     = C_S_AXIS_TDATA_WIDTH / NB;
  localparam int S     = (L == 1) ? 0 : $clog2(L);
  localparam int BPB   = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int BEATS = (C_LENGTH_IN_BYTES + BPB - 1) / BPB;
  localparam int REM   = C_LENGTH_IN_BYTES % BPB;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BPB-1:0] FINAL_KEEP = (REM == 0) ? {BPB{1'b1}} :
                                          ({BPB{1'b1}} >> (BPB - REM));

  state_t                    state;
  state_t                    state_nxt;
  logic                      start_q;
  logic                      start_edge;
  logic [2:0]                ptr;
  logic [CW-1:0]             beat;
  logic                      hs;
  logic                      last_beat;
  logic                      data_err;
  logic [BPB-1:0]            exp_keep;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] exp_data;
  logic [3:0]                new_err;

  assign start_edge    = ap_start & ~start_q;
  assign s_axis_tready = (state == ST_RUN) && C_READY_PATTERN[ptr];
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign last_beat     = (beat == CW'(BEATS - 1));
  assign exp_keep      = last_beat ? FINAL_KEEP : {BPB{1'b1}};
  assign exp_data      = C_S_AXIS_TDATA_WIDTH'(expected_beat(32'(beat), C_S_AXIS_TDATA_WIDTH, NB, S));
  assign ap_done       = (state == ST_DONE);

  myadder1_example_counter #(
    .WIDTH (CW)
  ) u_beat_counter (
    .clk   (aclk),
    .rst   (areset),
    .clear ((state == ST_IDLE) && start_edge),
    .incr  (hs),
    .count (beat)
  );

  // Bytes with tkeep low are don't-care and never flag a data error.
  always_comb begin
    data_err = 1'b0;
    for (int i = 0; i < BPB; i++) begin
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != exp_data[8*i +: 8]))
        data_err = 1'b1;
    end
  end

  always_comb begin
    new_err                   = '0;
    new_err[ERR_DATA]         = data_err;
    new_err[ERR_EARLY_LAST]   = s_axis_tlast & ~last_beat;
    new_err[ERR_MISSING_LAST] = ~s_axis_tlast & last_beat;
    new_err[ERR_KEEP]         = (s_axis_tkeep != exp_keep);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_edge) state_nxt = ST_RUN;
      ST_RUN:  if (hs && (s_axis_tlast || last_beat)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      ptr       <= '0;
      err_flags <= '0;
      err_beat  <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= ap_start;
      ptr     <= (state == ST_RUN) ? ptr + 3'd1 : 3'd0;
      if ((state == ST_IDLE) && start_edge) begin
        err_flags <= '0;
        err_beat  <= '0;
      end else if (hs && (new_err != 4'd0)) begin
        err_flags <= err_flags | new_err;
        if (err_flags == 4'd0)
          err_beat <= 32'(beat);
      end
    end
  end

endmodule

// File: tb/tb_myadder1_example_number_checker.sv
// Randomised bench for the number checker: per-run beat plans drive the DUT,
// a reference model predicts the outcome and a monitor scores each ap_done.
module tb_myadder1_example_number_checker;

  localparam int         TW      = 128;
  localparam int         BPB     = TW / 8;
  localparam int         LEN     = 1000;
  localparam int         BEATS   = (LEN + BPB - 1) / BPB;
  localparam int         REM     = LEN % BPB;
  localparam logic [7:0] PATTERN = 8'b1010_0110;

  logic            aclk;
  logic            areset;
  logic            ap_start;
  logic            ap_done;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [TW-1:0]   s_axis_tdata;
  logic [BPB-1:0]  s_axis_tkeep;
  logic            s_axis_tlast;
  logic [3:0]      err_flags;
  logic [31:0]     err_beat;

  myadder1_example_number_checker #(
    .C_S_AXIS_TDATA_WIDTH (TW),
    .C_NUMBER_BIT_WIDTH   (32),
    .C_LENGTH_IN_BYTES    (LEN),
    .C_READY_PATTERN      (PATTERN)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .err_flags     (err_flags),
    .err_beat      (err_beat)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  flags;
    logic [31:0] beat;
    int          n;
  } exp_t;

  exp_t           sb[$];
  int             tests = 0;
  int             fails = 0;
  int             mon_beats = 0;
  logic [BPB-1:0] keep_plan[BEATS];
  bit             last_plan[BEATS];
  int             flip_bit[BEATS];
  logic [BPB-1:0] final_keep;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Generator pattern: 32-bit lane n of beat b holds b*4 + n.
  function automatic logic [TW-1:0] gen_word(input int b);
    logic [TW-1:0] w;
    for (int n = 0; n < TW / 32; n++)
      w[n*32 +: 32] = 32'(b * 4 + n);
    return w;
  endfunction

  function automatic exp_t model();
    exp_t           e;
    logic [3:0]     bad;
    logic [BPB-1:0] ek;
    e.flags = 4'd0;
    e.beat  = 32'd0;
    e.n     = 0;
    for (int b = 0; b < BEATS; b++) begin
      bad = 4'd0;
      ek  = (b == BEATS - 1) ? final_keep : {BPB{1'b1}};
      if (flip_bit[b] >= 0 && keep_plan[b][flip_bit[b] / 8]) bad[0] = 1'b1;
      if (last_plan[b] && b < BEATS - 1)                     bad[1] = 1'b1;
      if (!last_plan[b] && b == BEATS - 1)                   bad[2] = 1'b1;
      if (keep_plan[b] != ek)                                bad[3] = 1'b1;
      if (bad != 4'd0 && e.flags == 4'd0) e.beat = 32'(b);
      e.flags = e.flags | bad;
      e.n     = b + 1;
      if (last_plan[b]) break;
    end
    return e;
  endfunction

  task automatic plan_clean();
    for (int b = 0; b < BEATS; b++) begin
      keep_plan[b] = (b == BEATS - 1) ? final_keep : {BPB{1'b1}};
      last_plan[b] = (b == BEATS - 1);
      flip_bit[b]  = -1;
    end
  endtask

  task automatic drive_beat(input int b);
    logic [TW-1:0] w;
    w = gen_word(b);
    if (b < BEATS) begin
      if (flip_bit[b] >= 0) w = w ^ (TW'(1) << flip_bit[b]);
      for (int i = 0; i < BPB; i++)
        if (!keep_plan[b][i]) w[8*i +: 8] = 8'($urandom);
      s_axis_tkeep = keep_plan[b];
      s_axis_tlast = last_plan[b];
    end else begin
      s_axis_tkeep = {BPB{1'b1}};
      s_axis_tlast = 1'b0;
    end
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic do_run(input int reset_at, input bit hold_start, input int restart_at, input int vld_pct);
    exp_t e;
    int   b;
    int   k;
    int   cyc;
    bit   hs;
    e = model();
    if (reset_at < 0) sb.push_back(e);
    @(negedge aclk); ap_start = 1'b1;
    @(negedge aclk); ap_start = hold_start;
    b = 0; k = 0; cyc = 0;
    while (b < e.n) begin
      ap_start = hold_start || (b == restart_at);
      if ($urandom_range(99) < vld_pct) drive_beat(b);
      else s_axis_tvalid = 1'b0;
      check("tready_pattern", 64'(s_axis_tready), 64'(PATTERN[k % 8]));
      if (b == reset_at) begin
        check("pre_reset_flags", 64'(err_flags), 64'(4'b0001));
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_flags", 64'(err_flags), 64'd0);
        check("rst_beat", 64'(err_beat), 64'd0);
        ap_start = 1'b0;
        repeat (10) @(negedge aclk);
        return;
      end
      hs = s_axis_tvalid && s_axis_tready;
      @(negedge aclk);
      k++;
      if (hs) b++;
      cyc++;
      if (cyc > 4000) begin
        check("run_timeout", 64'd1, 64'd0);
        break;
      end
    end
    drive_beat(b);
    check("done_pulse", 64'(ap_done), 64'd1);
    check("done_tready", 64'(s_axis_tready), 64'd0);
    @(negedge aclk);
    check("done_single", 64'(ap_done), 64'd0);
    check("idle_tready", 64'(s_axis_tready), 64'd0);
    if (hold_start) begin
      repeat (20) begin
        @(negedge aclk);
        check("hold_no_restart", 64'(s_axis_tready), 64'd0);
      end
    end
    s_axis_tvalid = 1'b0;
    ap_start = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  // Monitor: counts accepted beats and scores each completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      #1;
      if (areset) begin
        mon_beats = 0;
      end else begin
        if (s_axis_tvalid && s_axis_tready) mon_beats++;
        if (ap_done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("err_flags", 64'(err_flags), 64'(e.flags));
            if (e.flags != 4'd0) check("err_beat", 64'(err_beat), 64'(e.beat));
            check("beats_accepted", 64'(mon_beats), 64'(e.n));
          end
          mon_beats = 0;
        end
      end
    end
  end

  initial begin
    final_keep    = (REM == 0) ? {BPB{1'b1}} : BPB'((32'd1 << REM) - 32'd1);
    areset        = 1'b1;
    ap_start      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_tready", 64'(s_axis_tready), 64'd0);
    check("reset_done", 64'(ap_done), 64'd0);
    check("reset_flags", 64'(err_flags), 64'd0);
    check("reset_beat", 64'(err_beat), 64'd0);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    plan_clean(); do_run(-1, 0, -1, 100);
    plan_clean(); do_run(-1, 0, -1, 60);
    plan_clean(); flip_bit[37] = 64;            do_run(-1, 0, -1, 100);
    plan_clean(); last_plan[50] = 1'b1;         do_run(-1, 0, -1, 90);
    plan_clean(); last_plan[BEATS-1] = 1'b0;    do_run(-1, 0, -1, 100);
    plan_clean(); keep_plan[BEATS-1] = '1;      do_run(-1, 0, -1, 100);
    plan_clean(); flip_bit[BEATS-1] = 8*12 + 3; do_run(-1, 0, -1, 100);
    plan_clean(); flip_bit[20] = 5; keep_plan[20] = 16'h7FFF; last_plan[20] = 1'b1;
    do_run(-1, 0, -1, 100);
    plan_clean(); flip_bit[5] = 100; keep_plan[30] = 16'hFFFE; do_run(-1, 0, -1, 70);
    repeat (3) begin
      plan_clean();
      for (int b = 0; b < BEATS; b++)
        if ($urandom_range(15) == 0) flip_bit[b] = $urandom_range(TW - 1);
      do_run(-1, 0, -1, 80);
    end
    plan_clean(); flip_bit[3] = 0; do_run(10, 0, -1, 100);
    plan_clean(); do_run(-1, 0, -1, 100);
    plan_clean(); do_run(-1, 1, -1, 100);
    plan_clean(); do_run(-1, 0, 25, 100);

    repeat (4) @(negedge aclk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
